// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector.
// Pattern and length are loaded with a one-cycle strobe. Serial bits are
// qualified by i_valid. Matching can overlap or not. The block outputs a
// registered match pulse and a saturating match counter.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   UNARMED | no legal pattern loaded; serial input ignored
//   HUNT    | legal pattern loaded, shifting bits, no match now
//   MATCH   | the previous accepted bit completed a match (o=1)
module seq_detector_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap,
  input  logic               i_valid,
  input  logic               i,
  input  logic               clr_cnt,
  output logic               o,
  output logic               armed,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {
    S_UNARMED = 2'd0,
    S_HUNT    = 2'd1,
    S_MATCH   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               len_ok;
  logic [MAX_LEN-1:0] nhist;
  logic [LEN_W-1:0]   nfill;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  assign accept = i_valid && (state_q != S_UNARMED) && !load;
  assign len_ok = (len_in != '0) && (len_in <= LEN_W'(MAX_LEN));
  assign nhist  = {hist_q[MAX_LEN-2:0], i};
  assign nfill  = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

  // Select only the low len_q history bits for the compare.
  always_comb begin
    len_mask = '0;
    for (int b = 0; b < MAX_LEN; b++) begin
      len_mask[b] = (LEN_W'(b) < len_q);
    end
  end

  // A match needs enough fresh bits and equality on the live window;
  // the UNARMED gate in accept keeps len_q=0 from ever matching.
  assign hit = accept && (nfill >= len_q) && (((nhist ^ pat_q) & len_mask) == '0);

  // Next history/fill: load clears, a non-overlapping match restarts the fill.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = nhist;
      fill_d = (hit && !overlap) ? '0 : nfill;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_UNARMED;
    else        state_q <= state_d;
  end

  // FSM next-state logic; load overrides everything, including a pending match.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = len_ok ? S_HUNT : S_UNARMED;
    end else begin
      unique case (state_q)
        S_UNARMED: state_d = S_UNARMED;
        S_HUNT:    state_d = hit ? S_MATCH : S_HUNT;
        S_MATCH:   state_d = hit ? S_MATCH : S_HUNT;
        default:   state_d = S_UNARMED;
      endcase
    end
  end

  // FSM outputs decoded straight from the state register.
  always_comb begin
    o     = (state_q == S_MATCH);
    armed = (state_q != S_UNARMED);
  end

  // Pattern, length, history and fill registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pat_q  <= '0;
      len_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      if (load) begin
        pat_q <= pat_in;
        len_q <= len_ok ? len_in : '0;
      end
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  // Saturating match counter; clear beats a coincident match.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: a table of per-cycle vectors plus a
// hand-written async-reset sequence. Two instances share stimulus; the
// second has a 2-bit counter so saturation is visible alongside the 8-bit one.
module tb_seq_detector_prog;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;

   logic               clk;
   logic               n_rst;
   logic               load;
   logic [MAX_LEN-1:0] pat_in;
   logic [LEN_W-1:0]   len_in;
   logic               overlap;
   logic               i_valid;
   logic               i;
   logic               clr_cnt;

   logic               o_a, armed_a;
   logic [7:0]         cnt_a;
   logic               o_b, armed_b;
   logic [1:0]         cnt_b;

   int n_vec;
   int n_miss;

   typedef struct {
      logic       ld;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ov;
      logic       v;
      logic       bit_i;
      logic       clr;
      logic       eo;
      logic       ea;
      int         ec;
   } vec_t;

   vec_t vq[$];

   seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
      .clk(clk), .n_rst(n_rst), .load(load), .pat_in(pat_in), .len_in(len_in),
      .overlap(overlap), .i_valid(i_valid), .i(i), .clr_cnt(clr_cnt),
      .o(o_a), .armed(armed_a), .match_cnt(cnt_a)
   );

   seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
      .clk(clk), .n_rst(n_rst), .load(load), .pat_in(pat_in), .len_in(len_in),
      .overlap(overlap), .i_valid(i_valid), .i(i), .clr_cnt(clr_cnt),
      .o(o_b), .armed(armed_b), .match_cnt(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                      input logic ov, input logic v, input logic b, input logic clr,
                      input logic eo, input logic ea, input int ec);
      vec_t t;
      t.ld = ld; t.pat = pat; t.len = len; t.ov = ov; t.v = v; t.bit_i = b;
      t.clr = clr; t.eo = eo; t.ea = ea; t.ec = ec;
      vq.push_back(t);
   endtask

   task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                        input logic ov, input logic v, input logic b, input logic clr);
      load = ld; pat_in = pat; len_in = len; overlap = ov;
      i_valid = v; i = b; clr_cnt = clr;
   endtask

   // Compare both instances against one expectation; the 2-bit counter
   // expectation is the 8-bit one clipped at 3.
   task automatic check(input string name, input logic eo, input logic ea, input int ec);
      int ec_b;
      ec_b = (ec > 3) ? 3 : ec;
      n_vec++;
      if (o_a !== eo) begin
         $display("FAIL %s o: got %b want %b", name, o_a, eo);
         n_miss++;
      end
      if (armed_a !== ea) begin
         $display("FAIL %s armed: got %b want %b", name, armed_a, ea);
         n_miss++;
      end
      if (int'(cnt_a) != ec) begin
         $display("FAIL %s match_cnt: got %0d want %0d", name, cnt_a, ec);
         n_miss++;
      end
      if (o_b !== eo || armed_b !== ea) begin
         $display("FAIL %s cnt2 o/armed: got %b/%b want %b/%b", name, o_b, armed_b, eo, ea);
         n_miss++;
      end
      if (int'(cnt_b) != ec_b) begin
         $display("FAIL %s cnt2 match_cnt: got %0d want %0d", name, cnt_b, ec_b);
         n_miss++;
      end
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      n_rst  = 1'b0;
      drive(0, 8'h00, 4'd0, 0, 0, 0, 0);

      //  ld pat    len ov v  i  clr | o  a  cnt
      // overlap on, 1101 over stream 1101101
      add(1, 8'h0D, 4, 1, 0, 0, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 0, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 1);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 0, 0,  0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 2);
      add(0, 8'h00, 0, 1, 0, 0, 0,  0, 1, 2);
      // non-overlap, same stream
      add(1, 8'h0D, 4, 0, 0, 0, 0,  0, 1, 2);
      add(0, 8'h00, 0, 0, 1, 1, 0,  0, 1, 2);
      add(0, 8'h00, 0, 0, 1, 1, 0,  0, 1, 2);
      add(0, 8'h00, 0, 0, 1, 0, 0,  0, 1, 2);
      add(0, 8'h00, 0, 0, 1, 1, 0,  1, 1, 3);
      add(0, 8'h00, 0, 0, 1, 1, 0,  0, 1, 3);
      add(0, 8'h00, 0, 0, 1, 0, 0,  0, 1, 3);
      add(0, 8'h00, 0, 0, 1, 1, 0,  0, 1, 3);
      add(0, 8'h00, 0, 0, 0, 0, 1,  0, 1, 0);
      // back-to-back, pattern 11, overlap on
      add(1, 8'h03, 2, 1, 0, 0, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 1);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 2);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 3);
      add(0, 8'h00, 0, 1, 0, 0, 0,  0, 1, 3);
      // pattern 11, overlap off; 2-bit counter saturates here
      add(1, 8'h03, 2, 0, 0, 0, 0,  0, 1, 3);
      add(0, 8'h00, 0, 0, 1, 1, 0,  0, 1, 3);
      add(0, 8'h00, 0, 0, 1, 1, 0,  1, 1, 4);
      add(0, 8'h00, 0, 0, 1, 1, 0,  0, 1, 4);
      add(0, 8'h00, 0, 0, 1, 1, 0,  1, 1, 5);
      // load while in MATCH, then valid gaps that must not shift
      add(1, 8'h03, 2, 1, 0, 0, 0,  0, 1, 5);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 5);
      add(0, 8'h00, 0, 1, 0, 1, 0,  0, 1, 5);
      add(0, 8'h00, 0, 1, 0, 0, 0,  0, 1, 5);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 6);
      add(0, 8'h00, 0, 1, 0, 1, 0,  0, 1, 6);
      add(0, 8'h00, 0, 1, 0, 0, 1,  0, 1, 0);
      // illegal lengths 0 and 9 leave the detector unarmed
      add(1, 8'hFF, 0, 1, 0, 0, 0,  0, 0, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 0, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 0, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 0, 0);
      add(1, 8'hFF, 9, 1, 0, 0, 0,  0, 0, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 0, 0);
      // mid-stream reload to 101 discards the partial 110 history
      add(1, 8'h0D, 4, 1, 0, 0, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 0, 0,  0, 1, 0);
      add(1, 8'h05, 3, 1, 0, 0, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 0, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 1);
      // load with a valid bit in the same cycle (also load during MATCH)
      add(1, 8'h03, 2, 1, 1, 1, 0,  0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 2);
      // clear coincident with a match: o pulses, count goes to 0
      add(0, 8'h00, 0, 1, 1, 1, 1,  1, 1, 0);
      add(0, 8'h00, 0, 1, 1, 0, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 1, 0,  1, 1, 1);
      // len=1, non-overlap: every accepted 1 matches
      add(1, 8'h01, 1, 0, 0, 0, 0,  0, 1, 1);
      add(0, 8'h00, 0, 0, 1, 1, 0,  1, 1, 2);
      add(0, 8'h00, 0, 0, 1, 1, 0,  1, 1, 3);
      add(0, 8'h00, 0, 0, 1, 0, 0,  0, 1, 3);
      add(0, 8'h00, 0, 0, 1, 1, 0,  1, 1, 4);
      add(0, 8'h00, 0, 0, 0, 0, 0,  0, 1, 4);

      // reset state, checked while reset is held
      #3;
      check("reset_hold", 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", 0, 0, 0);

      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].ld, vq[k].pat, vq[k].len, vq[k].ov, vq[k].v, vq[k].bit_i, vq[k].clr);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", k), vq[k].eo, vq[k].ea, vq[k].ec);
      end

      // async reset while o is high
      drive(1, 8'h01, 4'd1, 1, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 8'h00, 4'd0, 1, 1, 1, 0);
      @(posedge clk); #1;
      check("pre_reset_match", 1, 1, 5);
      drive(0, 8'h00, 4'd0, 1, 0, 0, 0);
      #2;
      n_rst = 1'b0;
      #1;
      check("async_reset_now", 0, 0, 0);
      #2;
      n_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(0, 8'h00, 4'd0, 1, 1, 1, 0);
         @(posedge clk); #1;
         check($sformatf("post_reset_bit%0d", k), 0, 0, 0);
      end
      drive(1, 8'h01, 4'd1, 1, 0, 0, 0);
      @(posedge clk); #1;
      check("post_reset_load", 0, 1, 0);
      drive(0, 8'h00, 4'd0, 1, 1, 1, 0);
      @(posedge clk); #1;
      check("post_reset_match", 1, 1, 1);
      drive(0, 8'h00, 4'd0, 1, 0, 0, 0);
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
